// File: rtl/risc_pkg.sv
// Shared definitions for the Risc pipeline: opcodes, instruction fields, IF FSM states.
package risc_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 25;

  localparam logic [6:0] OPCODE_HALT = 7'b1111111;
  localparam logic [6:0] OPCODE_NOP  = 7'b0000000;

  // Field layout: opcode 31:25, DR 24:20, SA 19:15, SB 14:10, imm 9:0
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] dr;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [9:0] imm;
  } inst_t;

  localparam logic [INST_W-1:0] INST_NOP = {OPCODE_NOP, 25'd0};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } if_state_t;

  // True when the word carries the HALT opcode
  function automatic logic is_halt(input logic [INST_W-1:0] inst);
    return inst[OPC_MSB:OPC_LSB] == OPCODE_HALT;
  endfunction

endpackage

// File: rtl/risc_if_stage_hold_buf.sv
// One-entry skid buffer holding a fetched {inst, pc} while decode is stalled.
module if_hold_buf #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [31:0]     push_inst,
  input  logic [PC_W-1:0] push_pc,
  output logic            full,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] pc
);

  // Flush beats push beats pop; push and pop never coincide in the fetch stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      inst <= 32'd0;
      pc   <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      inst <= push_inst;
      pc   <= push_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/risc_if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous imem, absorbs
// decode stalls, applies EX redirects and stops fetching after a HALT.
// Optional feature macro: IF_PERF_CNT_EN (fetch/bubble performance counters).
module risc_if_stage
  import risc_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_oen,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_inst,
  output logic [PC_W-1:0] if_pc,
  output logic            halt_fetched,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt
);

  if_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pend_v_q, pend_v_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic            halt_d;
  logic            out_load;
  logic            ld_valid;
  logic [31:0]     ld_inst;
  logic [PC_W-1:0] ld_pc;
  logic            buf_push, buf_pop, buf_flush, buf_full;
  logic [31:0]     buf_inst;
  logic [PC_W-1:0] buf_pc;

  if_hold_buf #(.PC_W(PC_W)) u_hold_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .pop       (buf_pop),
    .flush     (buf_flush),
    .push_inst (imem_rdata),
    .push_pc   (pend_pc_q),
    .full      (buf_full),
    .inst      (buf_inst),
    .pc        (buf_pc)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, PC and output-register control; redirect overrides stall and HALT
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_v_d  = 1'b0;
    pend_pc_d = pend_pc_q;
    halt_d    = halt_fetched;
    out_load  = 1'b0;
    ld_valid  = 1'b0;
    ld_inst   = INST_NOP;
    ld_pc     = '0;
    buf_push  = 1'b0;
    buf_pop   = 1'b0;
    buf_flush = 1'b0;
    if (redirect_valid) begin
      state_d   = RUN;
      pc_d      = redirect_pc;
      buf_flush = 1'b1;
      out_load  = 1'b1;
      halt_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (stall) begin
            // pc holds, so the in-flight word is the only one that needs parking
            buf_push = pend_v_q;
          end else begin
            pc_d      = pc_q + PC_W'(1);
            pend_v_d  = 1'b1;
            pend_pc_d = pc_q;
            out_load  = 1'b1;
            if (buf_full) begin
              buf_pop  = 1'b1;
              ld_valid = 1'b1;
              ld_inst  = buf_inst;
              ld_pc    = buf_pc;
            end else if (pend_v_q) begin
              ld_valid = 1'b1;
              ld_inst  = imem_rdata;
              ld_pc    = pend_pc_q;
            end
            if (ld_valid && is_halt(ld_inst)) begin
              state_d  = HALTED;
              halt_d   = 1'b1;
              pend_v_d = 1'b0;
            end
          end
        end
        HALTED: out_load = !stall;  // HALT consumed, bubble follows
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath registers: pc, in-flight tag, imem enable, output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      pend_v_q     <= 1'b0;
      pend_pc_q    <= '0;
      imem_oen     <= 1'b1;
      halt_fetched <= 1'b0;
      if_valid     <= 1'b0;
      if_inst      <= 32'd0;
      if_pc        <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_v_q     <= pend_v_d;
      pend_pc_q    <= pend_pc_d;
      imem_oen     <= (state_d != RUN);
      halt_fetched <= halt_d;
      if (out_load) begin
        if_valid <= ld_valid;
        if_inst  <= ld_inst;
        if_pc    <= ld_pc;
      end
    end
  end

  assign imem_addr = pc_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  // Saturating counters of consumed instructions and RUN-state bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (if_valid && !stall && (fetch_cnt_q != 32'hFFFF_FFFF))
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!if_valid && (state_q == RUN) && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  assign perf_fetch_cnt  = 32'd0;
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_risc_if_stage.sv
// Self-checking bench for risc_if_stage: directed scenarios then random
// stall/redirect traffic against a stream-level reference model.
module tb_risc_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_oen;
  logic [31:0] imem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        halt_fetched;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bit halt_addr [0:1023];

  risc_if_stage #(.PC_W(32), .RESET_PC(32'd0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_oen        (imem_oen),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .halt_fetched    (halt_fetched),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  // Program image: sequential words, HALT at flagged addresses
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a < 32'd1024 && halt_addr[a[9:0]]) return 32'hFE00_0000;
    return 32'h0400_0001 + a;
  endfunction

  function automatic logic word_is_halt(input logic [31:0] a);
    logic [31:0] w;
    w = word(a);
    return w[31:25] == 7'h7F;
  endfunction

  // Synchronous instruction memory
  always @(posedge clk) begin
    if (!imem_oen) imem_rdata <= word(imem_addr);
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the stage delivers addresses in program order; a stalled
  // edge freezes everything; startup and redirect cost a fixed number of
  // unstalled bubble edges; after a HALT is delivered nothing more arrives.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode  = M_IDLE;
  int          m_lat   = 0;
  logic [31:0] m_next  = 32'd0;
  logic        m_valid = 1'b0;
  logic [31:0] m_inst  = 32'd0;
  logic [31:0] m_pc    = 32'd0;
  logic        m_halt  = 1'b0;
  logic [31:0] m_fcnt  = 32'd0;
  logic [31:0] m_bcnt  = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE; m_lat <= 0; m_next <= 32'd0;
      m_valid <= 1'b0; m_inst <= 32'd0; m_pc <= 32'd0; m_halt <= 1'b0;
      m_fcnt <= 32'd0; m_bcnt <= 32'd0;
    end else begin
      if (m_valid && !stall) m_fcnt <= m_fcnt + 32'd1;
      if (!m_valid && m_mode == M_RUN) m_bcnt <= m_bcnt + 32'd1;
      if (redirect_valid) begin
        m_mode <= M_RUN; m_lat <= 1; m_next <= redirect_pc;
        m_valid <= 1'b0; m_inst <= 32'd0; m_halt <= 1'b0;
      end else if (m_mode == M_IDLE) begin
        m_mode <= M_RUN; m_lat <= 1;
      end else if (!stall) begin
        if (m_mode == M_HALT) begin
          m_valid <= 1'b0; m_inst <= 32'd0;
        end else if (m_lat > 0) begin
          m_lat <= m_lat - 1;
        end else begin
          m_valid <= 1'b1; m_inst <= word(m_next); m_pc <= m_next;
          m_next <= m_next + 32'd1;
          if (word_is_halt(m_next)) begin
            m_mode <= M_HALT; m_halt <= 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("if_valid", {63'd0, if_valid}, {63'd0, m_valid});
    if (m_valid) begin
      check("if_pc", {32'd0, if_pc}, {32'd0, m_pc});
      check("if_inst", {32'd0, if_inst}, {32'd0, m_inst});
    end else begin
      check("if_inst_nop", {32'd0, if_inst}, 64'd0);
    end
    check("halt_fetched", {63'd0, halt_fetched}, {63'd0, m_halt});
    check("imem_oen", {63'd0, imem_oen}, {63'd0, (m_mode != M_RUN)});
`ifdef IF_PERF_CNT_EN
    check("perf_fetch", {32'd0, perf_fetch_cnt}, {32'd0, m_fcnt});
    check("perf_bubble", {32'd0, perf_bubble_cnt}, {32'd0, m_bcnt});
`else
    check("perf_fetch", {32'd0, perf_fetch_cnt}, 64'd0);
    check("perf_bubble", {32'd0, perf_bubble_cnt}, 64'd0);
`endif
  end

  // Apply inputs at a falling edge and advance past one rising edge
  task automatic drive(input logic s, input logic r, input logic [31:0] t);
    stall = s; redirect_valid = r; redirect_pc = t;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, {63'd0, if_valid}, 64'd0);
    check({tag, "_inst"}, {32'd0, if_inst}, 64'd0);
    check({tag, "_pc"}, {32'd0, if_pc}, 64'd0);
    check({tag, "_halt"}, {63'd0, halt_fetched}, 64'd0);
    check({tag, "_oen"}, {63'd0, imem_oen}, 64'd1);
    check({tag, "_addr"}, {32'd0, imem_addr}, 64'd0);
    check({tag, "_fcnt"}, {32'd0, perf_fetch_cnt}, 64'd0);
    check({tag, "_bcnt"}, {32'd0, perf_bubble_cnt}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) halt_addr[i] = 1'b0;
    halt_addr[6] = 1'b1;
    for (int i = 200; i < 1024; i++) halt_addr[i] = ($urandom_range(0, 39) == 0);

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Straight-line: first valid after the 3rd edge
    repeat (3) drive(1'b0, 1'b0, 32'd0);
    check("lit_e3_valid", {63'd0, if_valid}, 64'd1);
    check("lit_e3_pc", {32'd0, if_pc}, 64'd0);
    check("lit_e3_inst", {32'd0, if_inst}, 64'h0400_0001);
    repeat (2) drive(1'b0, 1'b0, 32'd0);
    check("lit_e5_pc", {32'd0, if_pc}, 64'd2);

    // Three stalled edges hold pc 2, then 3, 4
    repeat (3) drive(1'b1, 1'b0, 32'd0);
    check("lit_stall_pc", {32'd0, if_pc}, 64'd2);
    check("lit_stall_inst", {32'd0, if_inst}, 64'h0400_0003);
    drive(1'b0, 1'b0, 32'd0);
    check("lit_unstall_pc3", {32'd0, if_pc}, 64'd3);
    drive(1'b0, 1'b0, 32'd0);
    check("lit_unstall_pc4", {32'd0, if_pc}, 64'd4);

    // Redirect to 100 while stalled: two bubbles then 100, 101
    drive(1'b1, 1'b1, 32'd100);
    check("lit_redir_bub1", {63'd0, if_valid}, 64'd0);
    drive(1'b0, 1'b0, 32'd0);
    check("lit_redir_bub2", {63'd0, if_valid}, 64'd0);
    drive(1'b0, 1'b0, 32'd0);
    check("lit_redir_pc100", {32'd0, if_pc}, 64'd100);
    drive(1'b0, 1'b0, 32'd0);
    check("lit_redir_pc101", {32'd0, if_pc}, 64'd101);

    // HALT at address 6
    drive(1'b0, 1'b1, 32'd5);
    drive(1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0);
    check("lit_pre_halt_pc", {32'd0, if_pc}, 64'd5);
    drive(1'b0, 1'b0, 32'd0);
    check("lit_halt_inst", {32'd0, if_inst}, 64'hFE00_0000);
    check("lit_halt_flag", {63'd0, halt_fetched}, 64'd1);
    check("lit_halt_oen", {63'd0, imem_oen}, 64'd1);
    drive(1'b0, 1'b0, 32'd0);
    check("lit_halt_consumed", {63'd0, if_valid}, 64'd0);
    check("lit_halt_sticky", {63'd0, halt_fetched}, 64'd1);

    // HALT loaded on the same edge as a redirect to 7: redirect wins
    drive(1'b0, 1'b1, 32'd5);
    check("lit_halt_cleared", {63'd0, halt_fetched}, 64'd0);
    repeat (2) drive(1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 32'd7);
    check("lit_race_halt", {63'd0, halt_fetched}, 64'd0);
    check("lit_race_valid", {63'd0, if_valid}, 64'd0);
    repeat (2) drive(1'b0, 1'b0, 32'd0);
    check("lit_race_pc7", {32'd0, if_pc}, 64'd7);

    // PC wraps modulo 2^32
    drive(1'b0, 1'b1, 32'hFFFF_FFFE);
    repeat (4) drive(1'b0, 1'b0, 32'd0);
    check("lit_wrap_pc", {32'd0, if_pc}, 64'd0);
    check("lit_wrap_valid", {63'd0, if_valid}, 64'd1);

    // Random stall/redirect traffic with one reset asserted mid-stall
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd300;
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        drive(($urandom_range(0, 99) < 30),
              ($urandom_range(0, 99) < 4),
              32'($urandom_range(0, 1023)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
